mem_bus_ctrl: RTL

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-requester controller for an asynchronous byte-wide RAM.
// Each request runs SETUP, WAIT_STATES cycles of STROBE and HOLD, then returns to IDLE.
// Optional build macro MEM_BUS_CTRL_POSTED_WRITE_EN: write ack is issued in SETUP
// instead of HOLD, while the bus sequence and busy stay unchanged.
//
// state  | meaning
// IDLE   | waiting for req; address_bus keeps the last address
// SETUP  | address (and write data) on the bus, strobes low
// STROBE | r or w high, down-counter tracks the remaining wait states
// HOLD   | strobes low, address/data held, normal ack pulse
module mem_bus_ctrl #(
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [14:0] addr,
  input  logic [7:0]  wdata,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [14:0] address_bus,
  inout  wire  [7:0]  data_bus,
  output logic        r,
  output logic        w
);

`ifdef MEM_BUS_CTRL_POSTED_WRITE_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  // STROBE lasts WAIT_STATES cycles; the counter reaches zero in the last one
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [7:0]  wdata_q;
  logic        drive_en;

  // the data bus is only ever driven by us for the whole body of a write
  assign data_bus = drive_en ? wdata_q : 8'bz;

  // sequencing FSM with all bus and requester outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      drive_en    <= 1'b0;
      ack         <= 1'b0;
      busy        <= 1'b0;
      r           <= 1'b0;
      w           <= 1'b0;
      rdata       <= '0;
      address_bus <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            state       <= SETUP;
            we_q        <= we;
            wdata_q     <= wdata;
            address_bus <= addr;
            busy        <= 1'b1;
            drive_en    <= we;
            ack         <= POSTED & we;
          end
        end
        SETUP: begin
          state <= STROBE;
          cnt   <= CNT_LOAD;
          ack   <= 1'b0;
          r     <= ~we_q;
          w     <= we_q;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
            r     <= 1'b0;
            w     <= 1'b0;
            ack   <= ~(POSTED & we_q);
            if (!we_q) begin
              rdata <= data_bus;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          state    <= IDLE;
          ack      <= 1'b0;
          busy     <= 1'b0;
          drive_en <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
